dispatch: RTL
=============

DISPATCH -- requirements
Module: dispatch

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: flush  in  1  pipeline flush; pause_ex  in  1  execute-stage backpressure.
REQ-003 SHALL have ports: dec_data1, dec_data2  in  DECODE_DATA_WIDTH each  decoded slot0/slot1 records, bit0 = valid.
REQ-004 SHALL have port: invalid_en  out  2  slots consumed this cycle, bit0 = slot0; the decode queue dequeues on this.
REQ-005 SHALL have ports: rf_raddr  out  4x5  regfile read addresses {s1r2,s1r1,s0r2,s0r1}; rf_rdata  in  4x32  read data, same cycle.
REQ-006 SHALL have ports: ex_fwd_we/mem_fwd_we  in  2 each; ex_fwd_addr/mem_fwd_addr  in  2x5 each; ex_fwd_data/mem_fwd_data  in  2x32 each; ex_is_load  in  2  EX slot is a load.
REQ-007 SHALL have port: priv_done  in  1  pulse when an issued privileged/CSR instruction commits.
REQ-008 SHALL have ports: ex_valid  out  2; ex_data1/ex_data2  out  DECODE_DATA_WIDTH each; ex_src1/ex_src2  out  2x32 each  resolved operands per slot.

Function
REQ-009 SHALL register all EX outputs, 1-cycle latency from invalid_en to ex_valid.
REQ-010 SHALL resolve each operand: read disabled -> 0; addr 0 -> 0; else EX forward (slot1 over slot0) over MEM forward over rf_rdata.
REQ-011 SHALL issue slot0 when valid, pause_ex=0, flush=0, state=RUN, and no load-use hazard (ex_is_load & ex_fwd_we on a source it reads).
REQ-012 SHALL issue slot1 only if slot0 issues and slot1 is valid with no RAW on slot0 dest (nonzero), no WAW, no load-use, neither slot privileged/CSR/exception, and slot0 not a branch.
REQ-013 SHALL drive invalid_en = {slot1 issued, slot0 issued}; never 2'b10.
REQ-014 SHALL, with pause_ex=1, hold EX registers and drive invalid_en=0.
REQ-015 SHALL, with flush=1, clear ex_valid to 0 next cycle, drive invalid_en=0, and force state to RUN; flush overrides pause_ex.
REQ-016 SHALL implement FSM RUN/PRIV_WAIT: RUN->PRIV_WAIT when a privileged or CSR instruction issues (issued alone); PRIV_WAIT->RUN on priv_done or flush; no issue in PRIV_WAIT.
REQ-017 SHALL, when slot0 is not issued and pause_ex=0, load ex_valid=0 (bubble).
REQ-018 SHALL pass exception fields unmodified; an instruction carrying an exception issues alone, operands 0.

Reset
REQ-019 SHALL on rst=1 at clk edge set ex_valid=0, ex_data*=0, ex_src*=0, state=RUN; invalid_en=0 while rst=1.
REQ-020 SHALL give rst precedence over flush, pause_ex and priv_done.

Configuration
REQ-021 SHALL compile dual issue with macro DISPATCH_DUAL_ISSUE_EN: defined -> REQ-012 applies; undefined -> slot1 never issued, invalid_en[1]=0, ex_valid[1]=0.

Structure
REQ-022 SHALL take DECODE_DATA_WIDTH, record field offsets, alusel branch code and FSM encodings from the shared defines header.
REQ-023 SHALL place operand forwarding in one sub-module, dispatch_fwd, instantiated four times.

Verification
REQ-024 SHALL cover: slot0 add r3<-r1,r2, slot1 add r5<-r4,r6 -> invalid_en=2'b11, ex_valid=2'b11 next cycle.
REQ-025 SHALL cover: slot1 reads r3 written by slot0 -> invalid_en=2'b01, slot1 issues next cycle alone.
REQ-026 SHALL cover: ex_is_load[0]=1 writing r7, slot0 reads r7 -> invalid_en=0, bubble, issue after load leaves EX.
REQ-027 SHALL cover: csrwr in slot0 -> issued alone, PRIV_WAIT, invalid_en=0 until priv_done, then RUN.
REQ-028 SHALL cover: EX fwd r1=0x11 and MEM fwd r1=0x22, rf r1=0x33 -> ex_src1=0x11; read r0 with EX fwd to r0 -> 0.
REQ-029 SHALL cover: flush with pause_ex=1 in PRIV_WAIT -> ex_valid=0, state RUN next cycle; without DISPATCH_DUAL_ISSUE_EN, independent pair -> 2'b01 per cycle.

Source files
------------

// File: rtl/dispatch_pkg.sv
// dispatch_pkg -- shared definitions for the dispatch stage.
//
// Contents:
//   DECODE_DATA_WIDTH  width of one decoded instruction record
//   *_BIT / *_LSB      field offsets inside a decoded record
//   ALUSEL_BRANCH      alusel code that marks a branch
//   dispatch_state_t   dispatch FSM encodings (RUN / PRIV_WAIT)
//   rec_* helpers      field extractors for a decoded record
//
// Record layout (bit 0 = valid):
//   [0] valid  [5:1] rs1  [6] rs1 read  [11:7] rs2  [12] rs2 read
//   [17:13] rd  [18] rd write  [22:19] alusel  [23] privileged
//   [24] csr  [25] exception  [31:26] exception code
package dispatch_pkg;

  localparam int DECODE_DATA_WIDTH = 32;

  localparam int VALID_BIT    = 0;
  localparam int RS1_LSB      = 1;
  localparam int RS1_RE_BIT   = 6;
  localparam int RS2_LSB      = 7;
  localparam int RS2_RE_BIT   = 12;
  localparam int RD_LSB       = 13;
  localparam int RD_WE_BIT    = 18;
  localparam int ALUSEL_LSB   = 19;
  localparam int ALUSEL_WIDTH = 4;
  localparam int PRIV_BIT     = 23;
  localparam int CSR_BIT      = 24;
  localparam int EXC_BIT      = 25;
  localparam int ECODE_LSB    = 26;

  localparam logic [ALUSEL_WIDTH-1:0] ALUSEL_BRANCH = 4'd6;

  typedef enum logic [0:0] {
    ST_RUN       = 1'b0,
    ST_PRIV_WAIT = 1'b1
  } dispatch_state_t;

  typedef logic [DECODE_DATA_WIDTH-1:0] dec_rec_t;

  function automatic logic [4:0] rec_rs1(input dec_rec_t r);
    return r[RS1_LSB +: 5];
  endfunction

  function automatic logic [4:0] rec_rs2(input dec_rec_t r);
    return r[RS2_LSB +: 5];
  endfunction

  function automatic logic [4:0] rec_rd(input dec_rec_t r);
    return r[RD_LSB +: 5];
  endfunction

  function automatic logic [ALUSEL_WIDTH-1:0] rec_alusel(input dec_rec_t r);
    return r[ALUSEL_LSB +: ALUSEL_WIDTH];
  endfunction

  // Privileged, CSR and excepting instructions all have to issue alone.
  function automatic logic rec_special(input dec_rec_t r);
    return r[PRIV_BIT] | r[CSR_BIT] | r[EXC_BIT];
  endfunction

endpackage

// File: rtl/dispatch_fwd.sv
// dispatch_fwd -- resolves one source operand.
//
// Ports:
//   re, addr                 operand read enable and register address
//   ex_we/ex_addr/ex_data    EX-stage forwarding, two slots
//   mem_we/mem_addr/mem_data MEM-stage forwarding, two slots
//   rf_data                  register file read data for addr
//   data                     resolved operand value
module dispatch_fwd (
  input  logic            re,
  input  logic [4:0]      addr,
  input  logic [1:0]      ex_we,
  input  logic [1:0][4:0] ex_addr,
  input  logic [1:0][31:0] ex_data,
  input  logic [1:0]      mem_we,
  input  logic [1:0][4:0] mem_addr,
  input  logic [1:0][31:0] mem_data,
  input  logic [31:0]     rf_data,
  output logic [31:0]     data
);

  // Youngest producer wins: within a stage slot1 is younger than slot0,
  // and EX is younger than MEM. r0 always reads as zero.
  always_comb begin
    data = '0;
    if (re && (addr != 5'd0)) begin
      if (ex_we[1] && (ex_addr[1] == addr))
        data = ex_data[1];
      else if (ex_we[0] && (ex_addr[0] == addr))
        data = ex_data[0];
      else if (mem_we[1] && (mem_addr[1] == addr))
        data = mem_data[1];
      else if (mem_we[0] && (mem_addr[0] == addr))
        data = mem_data[0];
      else
        data = rf_data;
    end
  end

endmodule

// File: rtl/dispatch.sv
// dispatch -- issues up to two decoded instructions per cycle into EX.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush, pause_ex      pipeline flush, execute-stage backpressure
//   dec_data1/2          slot0/slot1 decoded records (bit0 = valid)
//   invalid_en           slots consumed this cycle (bit0 = slot0)
//   rf_raddr, rf_rdata   regfile read ports {s1r2,s1r1,s0r2,s0r1}
//   ex_fwd_*, mem_fwd_*  forwarding from EX and MEM, ex_is_load flags
//   priv_done            privileged/CSR instruction committed
//   ex_valid, ex_data1/2, ex_src1/2   registered EX-stage outputs
//
// Configuration: define DISPATCH_DUAL_ISSUE_EN to allow slot1 to issue.
// Without it only slot0 ever issues.
module dispatch
  import dispatch_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          pause_ex,
  input  logic [DECODE_DATA_WIDTH-1:0]  dec_data1,
  input  logic [DECODE_DATA_WIDTH-1:0]  dec_data2,
  output logic [1:0]                    invalid_en,
  output logic [3:0][4:0]               rf_raddr,
  input  logic [3:0][31:0]              rf_rdata,
  input  logic [1:0]                    ex_fwd_we,
  input  logic [1:0][4:0]               ex_fwd_addr,
  input  logic [1:0][31:0]              ex_fwd_data,
  input  logic [1:0]                    mem_fwd_we,
  input  logic [1:0][4:0]               mem_fwd_addr,
  input  logic [1:0][31:0]              mem_fwd_data,
  input  logic [1:0]                    ex_is_load,
  input  logic                          priv_done,
  output logic [1:0]                    ex_valid,
  output logic [DECODE_DATA_WIDTH-1:0]  ex_data1,
  output logic [DECODE_DATA_WIDTH-1:0]  ex_data2,
  output logic [1:0][31:0]              ex_src1,
  output logic [1:0][31:0]              ex_src2
);

`ifdef DISPATCH_DUAL_ISSUE_EN
  localparam logic DUAL_ISSUE = 1'b1;
`else
  localparam logic DUAL_ISSUE = 1'b0;
`endif

  dispatch_state_t state;

  logic [3:0]       op_re;
  logic [3:0][4:0]  op_addr;
  logic [3:0][31:0] fwd_out;
  logic [3:0][31:0] op_val;

  logic lu0, lu1, raw, waw, pair_ok;
  logic issue0, issue1;

  // Operand order matches rf_raddr: 0=s0r1, 1=s0r2, 2=s1r1, 3=s1r2.
  assign op_addr = {rec_rs2(dec_data2), rec_rs1(dec_data2),
                    rec_rs2(dec_data1), rec_rs1(dec_data1)};
  assign op_re   = {dec_data2[RS2_RE_BIT], dec_data2[RS1_RE_BIT],
                    dec_data1[RS2_RE_BIT], dec_data1[RS1_RE_BIT]};
  assign rf_raddr = op_addr;

  for (genvar g = 0; g < 4; g++) begin : g_fwd
    dispatch_fwd u_fwd (
      .re       (op_re[g]),
      .addr     (op_addr[g]),
      .ex_we    (ex_fwd_we),
      .ex_addr  (ex_fwd_addr),
      .ex_data  (ex_fwd_data),
      .mem_we   (mem_fwd_we),
      .mem_addr (mem_fwd_addr),
      .mem_data (mem_fwd_data),
      .rf_data  (rf_rdata[g]),
      .data     (fwd_out[g])
    );
  end

  // An excepting instruction carries no useful operands into EX.
  always_comb begin
    op_val[0] = dec_data1[EXC_BIT] ? 32'd0 : fwd_out[0];
    op_val[1] = dec_data1[EXC_BIT] ? 32'd0 : fwd_out[1];
    op_val[2] = dec_data2[EXC_BIT] ? 32'd0 : fwd_out[2];
    op_val[3] = dec_data2[EXC_BIT] ? 32'd0 : fwd_out[3];
  end

  // A load in EX cannot forward yet, so a reader of its destination
  // must wait. r0 is never a real dependency.
  function automatic logic load_hit(input logic re, input logic [4:0] a,
                                    input logic [1:0] is_load,
                                    input logic [1:0] we,
                                    input logic [1:0][4:0] wa);
    return re && (a != 5'd0) &&
           ((is_load[0] && we[0] && (wa[0] == a)) ||
            (is_load[1] && we[1] && (wa[1] == a)));
  endfunction

  always_comb begin
    lu0 = load_hit(op_re[0], op_addr[0], ex_is_load, ex_fwd_we, ex_fwd_addr) |
          load_hit(op_re[1], op_addr[1], ex_is_load, ex_fwd_we, ex_fwd_addr);
    lu1 = load_hit(op_re[2], op_addr[2], ex_is_load, ex_fwd_we, ex_fwd_addr) |
          load_hit(op_re[3], op_addr[3], ex_is_load, ex_fwd_we, ex_fwd_addr);

    raw = dec_data1[RD_WE_BIT] && (rec_rd(dec_data1) != 5'd0) &&
          ((op_re[2] && (op_addr[2] == rec_rd(dec_data1))) ||
           (op_re[3] && (op_addr[3] == rec_rd(dec_data1))));
    waw = dec_data1[RD_WE_BIT] && dec_data2[RD_WE_BIT] &&
          (rec_rd(dec_data1) == rec_rd(dec_data2));

    pair_ok = dec_data2[VALID_BIT] && !raw && !waw && !lu1 &&
              !rec_special(dec_data1) && !rec_special(dec_data2) &&
              (rec_alusel(dec_data1) != ALUSEL_BRANCH);

    issue0 = !rst && dec_data1[VALID_BIT] && !pause_ex && !flush &&
             (state == ST_RUN) && !lu0;
    issue1 = issue0 && pair_ok && DUAL_ISSUE;

    invalid_en = {issue1, issue0};
  end

  // Dispatch FSM and EX registers. Flush beats pause; the FSM keeps
  // listening for priv_done even while EX is paused.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      ex_valid <= '0;
      ex_data1 <= '0;
      ex_data2 <= '0;
      ex_src1  <= '0;
      ex_src2  <= '0;
    end else if (flush) begin
      state    <= ST_RUN;
      ex_valid <= '0;
    end else begin
      case (state)
        ST_RUN:
          if (issue0 && (dec_data1[PRIV_BIT] || dec_data1[CSR_BIT]))
            state <= ST_PRIV_WAIT;
        ST_PRIV_WAIT:
          if (priv_done)
            state <= ST_RUN;
        default:
          state <= ST_RUN;
      endcase

      if (!pause_ex) begin
        ex_valid   <= {issue1, issue0};
        ex_data1   <= issue0 ? dec_data1 : '0;
        ex_data2   <= issue1 ? dec_data2 : '0;
        ex_src1[0] <= issue0 ? op_val[0] : 32'd0;
        ex_src2[0] <= issue0 ? op_val[1] : 32'd0;
        ex_src1[1] <= issue1 ? op_val[2] : 32'd0;
        ex_src2[1] <= issue1 ? op_val[3] : 32'd0;
      end
    end
  end

endmodule
